// File: rtl/core_run_pkg.sv
// Shared types and constants for the core run sequencer: job state encoding,
// register-index width and the default "halted" code of the core control FSM.
package core_run_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [3:0] HALT_STATE_DEFAULT = 4'hE;

  typedef enum logic [3:0] {
    IDLE,
    HOLD,
    LOAD_A,
    LOAD_B,
    RUN,
    READ_A,
    READ_B,
    DONE,
    ERR
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/run_watchdog.sv
// Loadable saturating down-counter; expired is high while the count sits at zero.
// Shared by the sequencer for both the reset-hold interval and the RUN watchdog.
module run_watchdog #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/core_run_sequencer.sv
// Job sequencer: holds the core in reset, preloads two argument registers, runs the core
// until it halts (or the watchdog fires), then reads back two result registers.
// Optional feature macro: RUN_CYCLE_COUNT_EN enables the RUN-cycle counter on cycle_count.
module core_run_sequencer
  import core_run_pkg::*;
#(
  parameter logic [REG_IDX_W-1:0] ARG_REG_A   = 5'd1,
  parameter logic [REG_IDX_W-1:0] ARG_REG_B   = 5'd2,
  parameter logic [REG_IDX_W-1:0] RES_REG_A   = 5'd1,
  parameter logic [REG_IDX_W-1:0] RES_REG_B   = 5'd2,
  parameter logic [3:0]           HALT_STATE  = HALT_STATE_DEFAULT,
  parameter int unsigned          HOLD_CYCLES = 4,
  parameter int unsigned          TIMEOUT     = 2**20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          arg_a,
  input  logic [31:0]          arg_b,
  input  logic [3:0]           core_state,
  input  logic [31:0]          rf_rdata,
  output logic                 core_rst,
  output logic                 rf_we,
  output logic [REG_IDX_W-1:0] rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [REG_IDX_W-1:0] rf_raddr,
  output logic                 busy,
  output logic                 done,
  output logic                 timed_out,
  output logic [63:0]          result,
  output logic [31:0]          cycle_count
);

  localparam int unsigned RUN_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
  localparam int unsigned WD_W   = max_u(max_u(RUN_W, HOLD_W), 1);

  localparam logic [WD_W-1:0] HOLD_LOAD = WD_W'(HOLD_CYCLES - 1);
  localparam logic [WD_W-1:0] RUN_LOAD  = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

  state_e          state;
  state_e          state_next;
  logic            wd_load;
  logic [WD_W-1:0] wd_load_value;
  logic            wd_enable;
  logic            wd_expired;
  logic            accept;

  assign accept = (state == IDLE) && start && !abort;

  run_watchdog #(
    .WIDTH(WD_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .load      (wd_load),
    .load_value(wd_load_value),
    .enable    (wd_enable),
    .expired   (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next    = state;
    wd_load       = 1'b0;
    wd_load_value = '0;
    wd_enable     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next    = HOLD;
          wd_load       = 1'b1;
          wd_load_value = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (wd_expired) state_next = LOAD_A;
        else            wd_enable  = 1'b1;
      end
      LOAD_A: state_next = LOAD_B;
      LOAD_B: begin
        state_next    = RUN;
        wd_load       = 1'b1;
        wd_load_value = RUN_LOAD;
      end
      RUN: begin
        // Halt is tested first so a halt on the expiry cycle still completes the job.
        if (core_state == HALT_STATE)            state_next = READ_A;
        else if ((TIMEOUT != 0) && wd_expired)   state_next = ERR;
        else                                     wd_enable  = 1'b1;
      end
      READ_A:  state_next = READ_B;
      READ_B:  state_next = DONE;
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      wd_load    = 1'b0;
      wd_enable  = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rst  <= 1'b1;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      rf_raddr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      result    <= '0;
    end else begin
      core_rst <= !(state_next inside {RUN, READ_A, READ_B});
      rf_we    <= (state_next == LOAD_A) || (state_next == LOAD_B);
      busy     <= !(state_next inside {IDLE, DONE, ERR});
      done     <= (state_next == DONE);

      if (state_next == LOAD_A) begin
        rf_waddr <= ARG_REG_A;
        rf_wdata <= arg_a;
      end else if (state_next == LOAD_B) begin
        rf_waddr <= ARG_REG_B;
        rf_wdata <= arg_b;
      end

      if (state_next == READ_A)      rf_raddr <= RES_REG_A;
      else if (state_next == READ_B) rf_raddr <= RES_REG_B;

      if (accept)                  timed_out <= 1'b0;
      else if (state_next == ERR)  timed_out <= 1'b1;

      if ((state == READ_A) && (state_next == READ_B)) result[63:32] <= rf_rdata;
      if ((state == READ_B) && (state_next == DONE))   result[31:0]  <= rf_rdata;
    end
  end

`ifdef RUN_CYCLE_COUNT_EN
  logic [31:0] run_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cycles <= '0;
    end else if (accept) begin
      run_cycles <= '0;
    end else if ((state == RUN) && (run_cycles != '1)) begin
      run_cycles <= run_cycles + 32'd1;
    end
  end

  assign cycle_count = run_cycles;
`else
  assign cycle_count = 32'd0;
`endif

endmodule
